// File: rtl/led_display_row_fetcher_if.sv
// Bus bundle between the row fetcher, the frame RAM and the LED row driver.
//   master : fetcher side (drives RAM address/strobe and the presented row)
//   slave  : RAM + row-consumer side (drives read data and row ready)
// Signals:
//   ram_rd_en_out / ram_address_out / ram_rdata_in  - RAM read port
//   row_out / row_valid_out / row_ready_in          - row handshake
//   row_address_out / frame_sel_out                 - tags of the presented row
interface led_display_row_fetcher_if #(
  parameter int unsigned ROW_WORDS  = 12,
  parameter int unsigned NUM_ROWS   = 16,
  parameter int unsigned RAM_ADDR_W = 32
);
  localparam int unsigned ROW_W      = 32 * ROW_WORDS;
  localparam int unsigned ROW_ADDR_W = $clog2(NUM_ROWS);

  logic                  ram_rd_en_out;
  logic [RAM_ADDR_W-1:0] ram_address_out;
  logic [31:0]           ram_rdata_in;
  logic [ROW_W-1:0]      row_out;
  logic                  row_valid_out;
  logic                  row_ready_in;
  logic [ROW_ADDR_W-1:0] row_address_out;
  logic                  frame_sel_out;

  modport master (
    output ram_rd_en_out, ram_address_out, row_out, row_valid_out, row_address_out,
           frame_sel_out,
    input  ram_rdata_in, row_ready_in
  );

  modport slave (
    input  ram_rd_en_out, ram_address_out, row_out, row_valid_out, row_address_out,
           frame_sel_out,
    output ram_rdata_in, row_ready_in
  );
endinterface

// File: rtl/led_display_row_fetcher.sv
// Fetches one display row (ROW_WORDS 32-bit words) from the frame RAM, tolerating a
// fixed RD_LATENCY read latency, assembles it and presents it with valid/ready.
// The next row fetch starts as soon as the current row is accepted. The frame
// buffer is latched once per frame, when the fetch of row 0 starts.
// Ports:
//   clk_in       - clock, rising edge
//   n_reset_in   - asynchronous active-low reset
//   enable_in    - permits starting a new row fetch
//   frame_sel_in - buffer to display, sampled at the start of row 0
//   bus          - RAM read port and row handshake (master side)
module led_display_row_fetcher #(
  parameter int unsigned           ROW_WORDS  = 12,
  parameter int unsigned           NUM_ROWS   = 16,
  parameter int unsigned           RD_LATENCY = 2,
  parameter int unsigned           RAM_ADDR_W = 32,
  parameter logic [RAM_ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                             clk_in,
  input  logic                             n_reset_in,
  input  logic                             enable_in,
  input  logic                             frame_sel_in,
  led_display_row_fetcher_if.master        bus
);
  localparam int unsigned ROW_W      = 32 * ROW_WORDS;
  localparam int unsigned ROW_ADDR_W = $clog2(NUM_ROWS);
  localparam int unsigned CNT_W      = $clog2(ROW_WORDS + 1);

  localparam logic [RAM_ADDR_W-1:0] FRAME_STRIDE = RAM_ADDR_W'(ROW_WORDS * NUM_ROWS);
  localparam logic [RAM_ADDR_W-1:0] ROW_STRIDE   = RAM_ADDR_W'(ROW_WORDS);
  localparam logic [CNT_W-1:0]      LAST_WORD    = CNT_W'(ROW_WORDS - 1);
  localparam logic [ROW_ADDR_W-1:0] LAST_ROW     = ROW_ADDR_W'(NUM_ROWS - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StPresent} state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        issue_cnt_q;
  logic [CNT_W-1:0]        cap_cnt_q;
  logic [ROW_ADDR_W-1:0]   row_idx_q;
  logic [ROW_ADDR_W-1:0]   row_addr_q;
  logic                    frame_q;
  logic                    frame_out_q;
  logic                    rd_en_q;
  logic                    valid_q;
  logic [RAM_ADDR_W-1:0]   addr_q;
  logic [ROW_W-1:0]        row_q;
  logic [RD_LATENCY-1:0]   cap_pipe_q;

  logic                    transfer;
  logic                    capture;
  logic [ROW_ADDR_W-1:0]   row_inc;
  logic [ROW_ADDR_W-1:0]   start_row;
  logic                    start_frame;
  logic [RAM_ADDR_W-1:0]   start_addr;

  assign transfer = valid_q && bus.row_ready_in;
  assign capture  = cap_pipe_q[RD_LATENCY-1];
  assign row_inc  = (row_idx_q == LAST_ROW) ? '0 : row_idx_q + ROW_ADDR_W'(1);

  // Row/frame/address of a fetch starting at the end of this cycle. From PRESENT a
  // fetch only starts on a transfer, so it targets the following row.
  assign start_row   = (state_q == StPresent) ? row_inc : row_idx_q;
  assign start_frame = (start_row == '0) ? frame_sel_in : frame_q;
  assign start_addr  = BASE_ADDR + (start_frame ? FRAME_STRIDE : '0)
                     + RAM_ADDR_W'(start_row) * ROW_STRIDE;

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state_q     <= StIdle;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      row_idx_q   <= '0;
      row_addr_q  <= '0;
      frame_q     <= 1'b0;
      frame_out_q <= 1'b0;
      rd_en_q     <= 1'b0;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      row_q       <= '0;
      cap_pipe_q  <= '0;
    end else begin
      // Read-strobe history: bit RD_LATENCY-1 marks cycles where rdata is valid.
      cap_pipe_q[0] <= rd_en_q;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        cap_pipe_q[i] <= cap_pipe_q[i-1];
      end

      if (capture && (state_q == StFetch || state_q == StDrain)) begin
        row_q     <= {row_q[ROW_W-33:0], bus.ram_rdata_in};
        cap_cnt_q <= cap_cnt_q + CNT_W'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (enable_in) begin
            state_q     <= StFetch;
            rd_en_q     <= 1'b1;
            addr_q      <= start_addr;
            issue_cnt_q <= '0;
            frame_q     <= start_frame;
          end
        end
        StFetch: begin
          if (issue_cnt_q == LAST_WORD) begin
            state_q <= StDrain;
            rd_en_q <= 1'b0;
          end else begin
            addr_q      <= addr_q + RAM_ADDR_W'(1);
            issue_cnt_q <= issue_cnt_q + CNT_W'(1);
          end
        end
        StDrain: begin
          if (capture && cap_cnt_q == LAST_WORD) begin
            state_q     <= StPresent;
            valid_q     <= 1'b1;
            cap_cnt_q   <= '0;
            row_addr_q  <= row_idx_q;
            frame_out_q <= frame_q;
          end
        end
        StPresent: begin
          if (transfer) begin
            valid_q   <= 1'b0;
            row_idx_q <= start_row;
            if (enable_in) begin
              state_q     <= StFetch;
              rd_en_q     <= 1'b1;
              addr_q      <= start_addr;
              issue_cnt_q <= '0;
              frame_q     <= start_frame;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ram_rd_en_out   = rd_en_q;
  assign bus.ram_address_out = addr_q;
  assign bus.row_out         = row_q;
  assign bus.row_valid_out   = valid_q;
  assign bus.row_address_out = row_addr_q;
  assign bus.frame_sel_out   = frame_out_q;
endmodule

// File: tb/tb_led_display_row_fetcher.sv
module tb_led_display_row_fetcher;
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic enable = 1'b0;
  logic frame_sel = 1'b0;
  logic ready = 1'b0;
  logic sw_en = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   rd_cnt = 0;

  always #5 clk = ~clk;

  // Main DUT: defaults (12 words, latency 2)
  led_display_row_fetcher_if #(.ROW_WORDS(12), .NUM_ROWS(16), .RAM_ADDR_W(32)) if_d ();
  led_display_row_fetcher #(.ROW_WORDS(12), .NUM_ROWS(16), .RD_LATENCY(2)) dut (
    .clk_in(clk), .n_reset_in(n_reset), .enable_in(enable), .frame_sel_in(frame_sel),
    .bus(if_d));

  // Sweep DUTs: {2,1}, {12,4}, {32,3}
  led_display_row_fetcher_if #(.ROW_WORDS(2), .NUM_ROWS(16), .RAM_ADDR_W(32)) if_a ();
  led_display_row_fetcher #(.ROW_WORDS(2), .NUM_ROWS(16), .RD_LATENCY(1)) dut_a (
    .clk_in(clk), .n_reset_in(n_reset), .enable_in(sw_en), .frame_sel_in(1'b0), .bus(if_a));
  led_display_row_fetcher_if #(.ROW_WORDS(12), .NUM_ROWS(16), .RAM_ADDR_W(32)) if_b ();
  led_display_row_fetcher #(.ROW_WORDS(12), .NUM_ROWS(16), .RD_LATENCY(4)) dut_b (
    .clk_in(clk), .n_reset_in(n_reset), .enable_in(sw_en), .frame_sel_in(1'b0), .bus(if_b));
  led_display_row_fetcher_if #(.ROW_WORDS(32), .NUM_ROWS(16), .RAM_ADDR_W(32)) if_c ();
  led_display_row_fetcher #(.ROW_WORDS(32), .NUM_ROWS(16), .RD_LATENCY(3)) dut_c (
    .clk_in(clk), .n_reset_in(n_reset), .enable_in(sw_en), .frame_sel_in(1'b0), .bus(if_c));

  // RAM models: data = address, delayed by the read latency
  logic [31:0] pd [2];
  logic [31:0] pa [1];
  logic [31:0] pb [4];
  logic [31:0] pc [3];
  always @(posedge clk) begin
    pd[0] <= if_d.ram_address_out; pd[1] <= pd[0];
    pa[0] <= if_a.ram_address_out;
    pb[0] <= if_b.ram_address_out; pb[1] <= pb[0]; pb[2] <= pb[1]; pb[3] <= pb[2];
    pc[0] <= if_c.ram_address_out; pc[1] <= pc[0]; pc[2] <= pc[1];
    if (if_d.ram_rd_en_out) rd_cnt <= rd_cnt + 1;
  end
  assign if_d.ram_rdata_in = pd[1];
  assign if_a.ram_rdata_in = pa[0];
  assign if_b.ram_rdata_in = pb[3];
  assign if_c.ram_rdata_in = pc[2];
  assign if_d.row_ready_in = ready;
  assign if_a.row_ready_in = 1'b0;
  assign if_b.row_ready_in = 1'b0;
  assign if_c.row_ready_in = 1'b0;

  function automatic logic [383:0] exp_row(input int unsigned base);
    logic [383:0] r;
    for (int k = 0; k < 12; k++) r[383-32*k -: 32] = 32'(base + k);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until valid is high; returns cycles taken, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!if_d.row_valid_out && n < 300);
    if (!if_d.row_valid_out) begin
      tests++; fails++;
      $display("FAIL wait_valid: valid still %b after %0d cycles, required 1", if_d.row_valid_out, n);
    end
  endtask

  // Checks tag and data of the presented row against the expected row/frame.
  task automatic check_row(input string name, input int r, input int f, input int n, input int n_exp);
    tests++;
    if (n !== n_exp) begin
      fails++; $display("FAIL %s latency: got %0d cycles, required %0d", name, n, n_exp);
    end
    tests++;
    if ({if_d.frame_sel_out, if_d.row_address_out} !== {1'(f), 4'(r)}) begin
      fails++; $display("FAIL %s tag: got frame %0d row %0d, required frame %0d row %0d",
                        name, if_d.frame_sel_out, if_d.row_address_out, f, r);
    end
    tests++;
    if (if_d.row_out !== exp_row(f * 192 + r * 12)) begin
      fails++; $display("FAIL %s data: got %h, required %h", name, if_d.row_out,
                        exp_row(f * 192 + r * 12));
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    tests++;
    if ({if_d.row_valid_out, if_d.ram_rd_en_out, if_d.ram_address_out, if_d.row_address_out,
         if_d.frame_sel_out} !== '0 || if_d.row_out !== '0) begin
      fails++; $display("FAIL reset_values: valid %b rd_en %b addr %h row_addr %0d frame %b",
                        if_d.row_valid_out, if_d.ram_rd_en_out, if_d.ram_address_out,
                        if_d.row_address_out, if_d.frame_sel_out);
    end
  endtask

  task automatic test_basic();
    int n;
    n_reset = 1'b1;
    tick();
    enable = 1'b1;
    ready = 1'b1;
    tick();
    tests++;
    if (if_d.ram_rd_en_out !== 1'b1 || if_d.ram_address_out !== 32'd0) begin
      fails++; $display("FAIL fetch_start: rd_en %b addr %0d, required 1 and 0",
                        if_d.ram_rd_en_out, if_d.ram_address_out);
    end
    for (int r = 0; r < 4; r++) begin
      wait_valid(n);
      check_row($sformatf("basic_row%0d", r), r, 0, r == 0 ? n + 1 : n, 15);
      if (r == 3) ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int rd0;
    int n;
    logic bad;
    rd0 = rd_cnt;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (if_d.row_valid_out !== 1'b1 || if_d.row_address_out !== 4'd3 ||
          if_d.row_out !== exp_row(36)) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++; $display("FAIL bp_hold: valid %b row_addr %0d, required 1 and 3 with stable data",
                        if_d.row_valid_out, if_d.row_address_out);
    end
    tests++;
    if (rd_cnt !== rd0) begin
      fails++; $display("FAIL bp_no_reads: got %0d reads, required 0", rd_cnt - rd0);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tests++;
    if (if_d.row_valid_out !== 1'b0 || if_d.ram_rd_en_out !== 1'b1 ||
        if_d.ram_address_out !== 32'd48) begin
      fails++; $display("FAIL bp_release: valid %b rd_en %b addr %0d, required 0 1 48",
                        if_d.row_valid_out, if_d.ram_rd_en_out, if_d.ram_address_out);
    end
    wait_valid(n);
    check_row("bp_next", 4, 0, n + 1, 15);
    tick(); tick();
    tests++;
    if (if_d.row_valid_out !== 1'b1 || if_d.row_address_out !== 4'd4) begin
      fails++; $display("FAIL bp_single_transfer: valid %b row_addr %0d, required 1 and 4",
                        if_d.row_valid_out, if_d.row_address_out);
    end
  endtask

  task automatic test_frame_wrap();
    int n;
    ready = 1'b1;
    for (int r = 5; r <= 16; r++) begin
      wait_valid(n);
      if (r == 16) check_row("frame_next_row0", 0, 1, n, 15);
      else check_row($sformatf("frame_row%0d", r), r, 0, n, 15);
      if (r == 5) frame_sel = 1'b1;
    end
  endtask

  task automatic test_enable_stop();
    int n;
    logic bad;
    for (int i = 0; i < 5; i++) tick();
    enable = 1'b0;
    wait_valid(n);
    check_row("stop_row1", 1, 1, n, 10);
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (if_d.row_valid_out !== 1'b0 || if_d.ram_rd_en_out !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++; $display("FAIL stop_idle: valid %b rd_en %b, required both 0 while idle",
                        if_d.row_valid_out, if_d.ram_rd_en_out);
    end
    enable = 1'b1;
    wait_valid(n);
    check_row("restart_row2", 2, 1, n, 15);
  endtask

  task automatic test_reset_mid();
    int n;
    for (int r = 3; r <= 6; r++) wait_valid(n);
    for (int i = 0; i < 13; i++) tick();
    tests++;
    if (if_d.ram_rd_en_out !== 1'b0 || if_d.row_valid_out !== 1'b0) begin
      fails++; $display("FAIL drain_state: rd_en %b valid %b, required 0 0",
                        if_d.ram_rd_en_out, if_d.row_valid_out);
    end
    #2 n_reset = 1'b0;
    #1;
    tests++;
    if ({if_d.row_valid_out, if_d.ram_rd_en_out, if_d.ram_address_out, if_d.row_address_out,
         if_d.frame_sel_out} !== '0 || if_d.row_out !== '0) begin
      fails++; $display("FAIL async_reset: valid %b rd_en %b addr %h row_addr %0d frame %b",
                        if_d.row_valid_out, if_d.ram_rd_en_out, if_d.ram_address_out,
                        if_d.row_address_out, if_d.frame_sel_out);
    end
    frame_sel = 1'b0;
    tick(); tick();
    n_reset = 1'b1;
    wait_valid(n);
    check_row("post_reset_row0", 0, 0, n, 15);
  endtask

  task automatic test_param_sweep();
    int fa, fb, fc;
    logic bad;
    fa = 0; fb = 0; fc = 0;
    sw_en = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (fa == 0 && if_a.row_valid_out) fa = n;
      if (fb == 0 && if_b.row_valid_out) fb = n;
      if (fc == 0 && if_c.row_valid_out) fc = n;
    end
    tests++;
    if (fa - 1 !== 3) begin fails++; $display("FAIL sweep_2_1 latency: got %0d, required 3", fa - 1); end
    tests++;
    if (fb - 1 !== 16) begin fails++; $display("FAIL sweep_12_4 latency: got %0d, required 16", fb - 1); end
    tests++;
    if (fc - 1 !== 35) begin fails++; $display("FAIL sweep_32_3 latency: got %0d, required 35", fc - 1); end
    bad = 1'b0;
    for (int k = 0; k < 2; k++) if (if_a.row_out[(1-k)*32 +: 32] !== 32'(k)) bad = 1'b1;
    for (int k = 0; k < 12; k++) if (if_b.row_out[(11-k)*32 +: 32] !== 32'(k)) bad = 1'b1;
    for (int k = 0; k < 32; k++) if (if_c.row_out[(31-k)*32 +: 32] !== 32'(k)) bad = 1'b1;
    tests++;
    if (bad) begin
      fails++; $display("FAIL sweep_word_order: got a=%h b_msw=%h c_msw=%h, required words 0..N-1",
                        if_a.row_out, if_b.row_out[383 -: 32], if_c.row_out[1023 -: 32]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_frame_wrap();
    test_enable_stop();
    test_reset_mid();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
